// File: rtl/kbcmd_sequencer.sv
// kbcmd_sequencer: PS/2 host-command generator. Debounced buttons map to
// command bytes, are queued in a small FIFO and issued through the writer's
// dataload/busy handshake, with ACK/resend/timeout handling and bounded retry.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for a queued command (retry count cleared)
// S_LOAD     | dataload strobe is high, data holds the FIFO head
// S_WAIT_TX  | waiting for busy to rise (timed) and then to fall
// S_WAIT_ACK | waiting for the keyboard reply (timed)
// S_RETRY    | reissue the command, or drop it once retries are used up
module kbcmd_sequencer #(
  parameter int                NBTN       = 4,
  parameter logic [NBTN*8-1:0] CMD_TABLE  = {8'h00, 8'hED, 8'hFC, 8'hFF},
  parameter logic [NBTN-1:0]   SW_MASK    = 4'b1000,
  parameter int                DEB_LEN    = 16,
  parameter int                DEB_ONES   = 12,
  parameter int                FIFO_DEPTH = 4,
  parameter int                TIMEOUT    = 2000000,
  parameter int                MAX_RETRY  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn,
  input  logic [7:0]      sw,
  input  logic            busy,
  input  logic            ps2error,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic [7:0]      data,
  output logic            dataload,
  output logic            ack,
  output logic            fail,
  output logic            fifo_full,
  output logic            idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [DEB_LEN-1:0] DEB_PAT = {{(DEB_LEN-DEB_ONES){1'b0}}, {DEB_ONES{1'b1}}};

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_WAIT_TX  = 3'd2;
  localparam logic [2:0] S_WAIT_ACK = 3'd3;
  localparam logic [2:0] S_RETRY    = 3'd4;

  logic [NBTN-1:0]    sync1_q, sync2_q;
  logic [DEB_LEN-1:0] hist_q [NBTN];
  logic [NBTN-1:0]    det;
  logic [NBTN-1:0]    req_q, req_d, push_sel;
  logic [7:0]         push_byte;
  logic               push, pop;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [AW:0]        wr_ptr_q, rd_ptr_q;
  logic               empty, full;
  logic [7:0]         head;

  logic [2:0]         state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic               seen_q, seen_d;
  logic [7:0]         data_q, data_d;
  logic               dataload_q, dataload_d;
  logic               ack_q, ack_d;
  logic               fail_q, fail_d;
  logic               timeout;

  // Synchronise each button and shift its history, newest sample in the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      for (int i = 0; i < NBTN; i++) hist_q[i] <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      for (int i = 0; i < NBTN; i++) hist_q[i] <= {hist_q[i][DEB_LEN-2:0], sync2_q[i]};
    end
  end

  // A press is the single cycle where the history shows a clean low-to-high edge.
  always_comb begin
    for (int i = 0; i < NBTN; i++) det[i] = (hist_q[i] == DEB_PAT);
  end

  // Pick the lowest pending request; a pulse on a pending channel merges into it.
  always_comb begin
    push_sel  = '0;
    push_byte = '0;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (req_q[i]) begin
        push_sel    = '0;
        push_sel[i] = 1'b1;
        push_byte   = SW_MASK[i] ? sw : CMD_TABLE[8*i +: 8];
      end
    end
    push  = (|req_q) && (!full || pop);
    req_d = (req_q | det) & ~(push ? push_sel : '0);
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Request bits and command FIFO storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      req_q <= req_d;
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_byte;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign timeout = (timer_q == TW'(TIMEOUT));

  // Command handshake sequencing; LOAD is only entered while the writer is idle.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    retry_d    = retry_q;
    seen_d     = seen_q;
    data_d     = data_q;
    dataload_d = 1'b0;
    ack_d      = 1'b0;
    fail_d     = 1'b0;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        retry_d = '0;
        if (!empty && !busy) begin
          state_d    = S_LOAD;
          dataload_d = 1'b1;
          data_d     = head;
        end
      end
      S_LOAD: begin
        state_d = S_WAIT_TX;
        timer_d = '0;
        seen_d  = 1'b0;
      end
      S_WAIT_TX: begin
        if (!seen_q) begin
          if (busy)         seen_d  = 1'b1;
          else if (timeout) state_d = S_RETRY;
          else              timer_d = timer_q + 1'b1;
        end else if (!busy) begin
          state_d = ps2error ? S_RETRY : S_WAIT_ACK;
          timer_d = '0;
        end
      end
      S_WAIT_ACK: begin
        if (rx_valid && rx_data == 8'hFA) begin
          pop     = 1'b1;
          ack_d   = 1'b1;
          state_d = S_IDLE;
        end else if ((rx_valid && rx_data == 8'hFE) || timeout) begin
          state_d = S_RETRY;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RETRY: begin
        if (retry_q < RW'(MAX_RETRY)) begin
          if (!busy) begin
            retry_d    = retry_q + 1'b1;
            state_d    = S_LOAD;
            dataload_d = 1'b1;
            data_d     = head;
          end
        end else begin
          pop     = 1'b1;
          fail_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      retry_q    <= '0;
      seen_q     <= 1'b0;
      data_q     <= '0;
      dataload_q <= 1'b0;
      ack_q      <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      seen_q     <= seen_d;
      data_q     <= data_d;
      dataload_q <= dataload_d;
      ack_q      <= ack_d;
      fail_q     <= fail_d;
    end
  end

  assign data      = data_q;
  assign dataload  = dataload_q;
  assign ack       = ack_q;
  assign fail      = fail_q;
  assign fifo_full = full;
  assign idle      = (state_q == S_IDLE) && empty;

endmodule
